inc_dec_counter_bank: RTL and testbench



---
 rtl/inc_dec_pkg.sv | 17 +
 rtl/inc_dec_chan.sv | 89 ++++++++
 rtl/inc_dec_counter_bank.sv | 42 ++++
 tb/tb_inc_dec_counter_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/inc_dec_pkg.sv
// Shared types and helpers for the inc/dec counter bank: saturation mode enum,
// bus slicing helper and the overflow flag reset value.
package inc_dec_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } sat_mode_e;

  localparam logic OVF_RESET = 1'b0;

  // LSB position of channel ch inside a flattened NUM_CH*width bus
  function automatic int unsigned chanLsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/inc_dec_chan.sv
// Single up/down counter with load, wrap or saturate arithmetic and an optional
// sticky overflow flag (enabled by defining INC_DEC_OVF_FLAG_EN).
module inc_dec_chan
  import inc_dec_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int SAT_MODE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf
);

  localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RESET_W  = WIDTH'(RESET_VAL);
  localparam bit               SATURATE = (SAT_MODE == int'(SAT));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] nxt_d;
  logic [WIDTH:0]   sumUp;
  logic [WIDTH:0]   sumDn;
  logic             boundary;

  // The extra top bit of each sum is the carry (up) or borrow (down) out of WIDTH
  always_comb begin
    sumUp    = {1'b0, cnt_q} + STEP_W;
    sumDn    = {1'b0, cnt_q} - STEP_W;
    nxt_d    = cnt_q;
    boundary = 1'b0;
    if (ld) begin
      nxt_d = ld_val;
    end else if (inc && !dec) begin
      boundary = sumUp[WIDTH];
      nxt_d    = (SATURATE && sumUp[WIDTH]) ? {WIDTH{1'b1}} : sumUp[WIDTH-1:0];
    end else if (dec && !inc) begin
      boundary = sumDn[WIDTH];
      nxt_d    = (SATURATE && sumDn[WIDTH]) ? {WIDTH{1'b0}} : sumDn[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RESET_W;
    end else begin
      cnt_q <= nxt_d;
    end
  end

  assign cnt = cnt_q;
  assign nxt = nxt_d;

`ifdef INC_DEC_OVF_FLAG_EN
  logic ovf_q;
  logic ovf_d;

  // Load wins over a boundary event, so a load both clears and blocks the flag
  always_comb begin
    ovf_d = ovf_q;
    if (ld) begin
      ovf_d = 1'b0;
    end else if (boundary) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= OVF_RESET;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unusedBoundary;
  assign unusedBoundary = boundary;
  assign ovf            = OVF_RESET;
`endif

endmodule

// File: rtl/inc_dec_counter_bank.sv
// Bank of NUM_CH independent inc/dec counters exposing registered (cnt) and
// next-value (nxt) views. Sticky ovf flags exist only with INC_DEC_OVF_FLAG_EN.
module inc_dec_counter_bank
  import inc_dec_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int SAT_MODE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       dec,
  input  logic [NUM_CH-1:0]       ld,
  input  logic [NUM_CH*WIDTH-1:0] ld_val,
  output logic [NUM_CH*WIDTH-1:0] cnt,
  output logic [NUM_CH*WIDTH-1:0] nxt,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar i = 0; i < NUM_CH; i++) begin : gChan
    inc_dec_chan #(
      .WIDTH    (WIDTH),
      .STEP     (STEP),
      .SAT_MODE (SAT_MODE),
      .RESET_VAL(RESET_VAL)
    ) uChan (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .ld    (ld[i]),
      .ld_val(ld_val[chanLsb(i, WIDTH) +: WIDTH]),
      .cnt   (cnt[chanLsb(i, WIDTH) +: WIDTH]),
      .nxt   (nxt[chanLsb(i, WIDTH) +: WIDTH]),
      .ovf   (ovf[i])
    );
  end

endmodule

// File: tb/tb_inc_dec_counter_bank.sv
// Bench for inc_dec_counter_bank: a wrapping 4-channel instance (RESET_VAL=5)
// and a saturating 2-channel instance (STEP=3) checked against a scoreboard.
module tb_inc_dec_counter_bank;

`ifdef INC_DEC_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  incA = '0, decA = '0, ldA = '0;
  logic [31:0] ldValA = '0;
  logic [31:0] cntA, nxtA;
  logic [3:0]  ovfA;

  logic [1:0]  incB = '0, decB = '0, ldB = '0;
  logic [15:0] ldValB = '0;
  logic [15:0] cntB, nxtB;
  logic [1:0]  ovfB;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [31:0] cntA;
    logic [3:0]  ovfA;
    logic [15:0] cntB;
    logic [1:0]  ovfB;
  } expEntry_t;

  expEntry_t sbQ[$];

  logic [7:0] mCntA[4];
  logic       mOvfA[4];
  logic [7:0] mCntB[2];
  logic       mOvfB[2];

  always #5 clk = ~clk;

  inc_dec_counter_bank #(
    .NUM_CH(4), .WIDTH(8), .STEP(1), .SAT_MODE(0), .RESET_VAL(5)
  ) dutA (
    .clk(clk), .rst(rst), .inc(incA), .dec(decA), .ld(ldA), .ld_val(ldValA),
    .cnt(cntA), .nxt(nxtA), .ovf(ovfA)
  );

  inc_dec_counter_bank #(
    .NUM_CH(2), .WIDTH(8), .STEP(3), .SAT_MODE(1), .RESET_VAL(0)
  ) dutB (
    .clk(clk), .rst(rst), .inc(incB), .dec(decB), .ld(ldB), .ld_val(ldValB),
    .cnt(cntB), .nxt(nxtB), .ovf(ovfB)
  );

  // Reference arithmetic done in plain integers: returns {boundary, next}
  function automatic logic [8:0] modelNext(input logic [7:0] c, input logic i, input logic d,
                                           input logic l, input logic [7:0] lv,
                                           input int step, input bit sat);
    int  v;
    bit  b;
    logic [7:0] n;
    b = 1'b0;
    n = c;
    if (l) begin
      n = lv;
    end else if (i && !d) begin
      v = int'(c) + step;
      b = (v > 255);
      n = (sat && b) ? 8'd255 : 8'(v % 256);
    end else if (d && !i) begin
      v = int'(c) - step;
      b = (v < 0);
      n = (sat && b) ? 8'd0 : 8'((v + 256) % 256);
    end
    return {b, n};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin mCntA[i] = 8'd5; mOvfA[i] = 1'b0; end
    for (int i = 0; i < 2; i++) begin mCntB[i] = 8'd0; mOvfB[i] = 1'b0; end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cntA"}, cntA, 32'h05050505);
    checkOutput({tag, "_ovfA"}, {28'd0, ovfA}, 32'd0);
    checkOutput({tag, "_cntB"}, {16'd0, cntB}, 32'd0);
    checkOutput({tag, "_ovfB"}, {30'd0, ovfB}, 32'd0);
  endtask

  // Drive one cycle of requests, check nxt immediately, scoreboard cnt/ovf for after the edge
  task automatic applyStimulus(input string tag,
                               input logic [3:0] iA, input logic [3:0] dA, input logic [3:0] lA,
                               input logic [31:0] lvA,
                               input logic [1:0] iB, input logic [1:0] dB, input logic [1:0] lB,
                               input logic [15:0] lvB);
    expEntry_t e;
    expEntry_t got;
    logic [8:0] r;
    logic [31:0] expNxtA;
    logic [15:0] expNxtB;
    @(negedge clk);
    incA = iA; decA = dA; ldA = lA; ldValA = lvA;
    incB = iB; decB = dB; ldB = lB; ldValB = lvB;
    #1;
    for (int i = 0; i < 4; i++) begin
      r = modelNext(mCntA[i], iA[i], dA[i], lA[i], lvA[i*8 +: 8], 1, 1'b0);
      expNxtA[i*8 +: 8] = r[7:0];
      mCntA[i] = r[7:0];
      if (OVF_EN) mOvfA[i] = lA[i] ? 1'b0 : (mOvfA[i] | r[8]);
      e.cntA[i*8 +: 8] = mCntA[i];
      e.ovfA[i] = mOvfA[i];
    end
    for (int i = 0; i < 2; i++) begin
      r = modelNext(mCntB[i], iB[i], dB[i], lB[i], lvB[i*8 +: 8], 3, 1'b1);
      expNxtB[i*8 +: 8] = r[7:0];
      mCntB[i] = r[7:0];
      if (OVF_EN) mOvfB[i] = lB[i] ? 1'b0 : (mOvfB[i] | r[8]);
      e.cntB[i*8 +: 8] = mCntB[i];
      e.ovfB[i] = mOvfB[i];
    end
    checkOutput({tag, "_nxtA"}, nxtA, expNxtA);
    checkOutput({tag, "_nxtB"}, {16'd0, nxtB}, {16'd0, expNxtB});
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkOutput({tag, "_cntA"}, cntA, got.cntA);
    checkOutput({tag, "_ovfA"}, {28'd0, ovfA}, {28'd0, got.ovfA});
    checkOutput({tag, "_cntB"}, {16'd0, cntB}, {16'd0, got.cntB});
    checkOutput({tag, "_ovfB"}, {30'd0, ovfB}, {30'd0, got.ovfB});
  endtask

  // Assert rst between edges with requests pending; they must be discarded
  task automatic midReset();
    @(negedge clk);
    incA = 4'hF; decA = '0; ldA = '0;
    incB = 2'b11; decB = '0; ldB = '0;
    #2 rst = 1'b1;
    #1;
    resetModel();
    checkResetState("midRst");
    @(posedge clk);
    #1;
    checkResetState("midRstEdge");
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  rI, rD, rL;
    logic [31:0] rV;
    logic [1:0]  sI, sD, sL;
    logic [15:0] sV;

    resetModel();
    #12;
    checkResetState("reset");
    rst = 1'b0;

    applyStimulus("loadA255", 4'b0000, 4'b0000, 4'b0001, 32'h000000FF,
                  2'b00, 2'b00, 2'b11, {8'd254, 8'd1});
    applyStimulus("wrapSat", 4'b0001, 4'b0000, 4'b0000, 32'h0,
                  2'b10, 2'b01, 2'b00, 16'h0);
    applyStimulus("satHold", 4'b0000, 4'b0000, 4'b0000, 32'h0,
                  2'b10, 2'b01, 2'b00, 16'h0);
    applyStimulus("prioLd", 4'b0001, 4'b0001, 4'b0001, 32'h00000040,
                  2'b01, 2'b01, 2'b01, 16'h0010);
    applyStimulus("prioHold", 4'b0001, 4'b0001, 4'b0000, 32'h0,
                  2'b11, 2'b11, 2'b00, 16'h0);
    applyStimulus("indep", 4'b0001, 4'b0100, 4'b1000, 32'h07000000,
                  2'b00, 2'b00, 2'b00, 16'h0);
    applyStimulus("ldSame", 4'b0000, 4'b0000, 4'b1000, 32'h07000000,
                  2'b00, 2'b00, 2'b00, 16'h0);
    applyStimulus("ldZero", 4'b0000, 4'b0000, 4'b0010, 32'h0,
                  2'b00, 2'b00, 2'b00, 16'h0);
    applyStimulus("wrapDn", 4'b0000, 4'b0010, 4'b0000, 32'h0,
                  2'b00, 2'b00, 2'b00, 16'h0);

    for (int n = 0; n < 30; n++) begin
      rI = 4'($urandom); rD = 4'($urandom);
      rL = 4'($urandom) & 4'($urandom) & 4'($urandom);
      rV = $urandom;
      sI = 2'($urandom); sD = 2'($urandom);
      sL = 2'($urandom) & 2'($urandom);
      sV = 16'($urandom);
      if (n % 5 == 0) begin
        rV = 32'hFE01FF00;
        sV = 16'hFD02;
      end
      applyStimulus("rand", rI, rD, rL, rV, sI, sD, sL, sV);
    end

    midReset();
    applyStimulus("postRst", 4'b0011, 4'b0100, 4'b0000, 32'h0,
                  2'b01, 2'b10, 2'b00, 16'h0);
    applyStimulus("postRst2", 4'b0000, 4'b0001, 4'b0000, 32'h0,
                  2'b00, 2'b01, 2'b00, 16'h0);

    checkOutput("sbEmpty", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
